// File: rtl/fft_pkg.sv
// Shared constants, sample type and index helper for the FFT output reorder block.
// Default geometry is an 8-point frame of 16-bit complex samples.
// bitrev() is elaboration-friendly: the loop bound is fixed and only the low n bits count.
package fft_pkg;

   localparam int N_DEF = 3;
   localparam int W_DEF = 16;

   typedef struct packed {
      logic signed [W_DEF-1:0] re;
      logic signed [W_DEF-1:0] im;
   } cplx_t;

   // Reverse the low n bits of idx; bits above n are dropped.
   function automatic logic [31:0] bitrev(input logic [31:0] idx, input int n);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < 32; b++) begin
         if (b < n) r = {r[30:0], idx[b]};
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame store: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none here; the owner's bank flags guarantee no read/write bank collision.
module fft_pingpong_ram
   import fft_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           i_wr_en,
   input  logic           i_wr_bank,
   input  logic [N-1:0]   i_wr_addr,
   input  logic [2*W-1:0] i_wr_dat,
   input  logic           i_rd_bank,
   input  logic [N-1:0]   i_rd_addr,
   output logic [2*W-1:0] o_rd_dat
);

   // Bank select is the address MSB so both banks share one flat array.
   logic [2*W-1:0] r_mem [2*(1<<N)];

   // Sample store; no reset, contents are only read after being written.
   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_dat;
   end

   assign o_rd_dat = r_mem[{i_rd_bank, i_rd_addr}];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural order through ping-pong banks.
// Latency: first sample valid one clock after the frame's last write; 1 sample/clk sustained.
// Backpressure: in_ready low while the write bank is still full; output holds while out_ready low.
module fft_bitrev_reorder
   import fft_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] in_real,
   input  logic signed [W-1:0] in_img,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] out_real,
   output logic signed [W-1:0] out_img,
   output logic                out_last
);

   localparam logic [N-1:0] LAST = {N{1'b1}};

   logic [1:0]     r_rst_sync;
   logic [1:0]     r_full;
   logic           r_wr_bank;
   logic           r_rd_bank;
   logic [N-1:0]   r_wr_cnt;
   logic [N-1:0]   r_rd_cnt;
   logic [2*W-1:0] r_out_dat;
   logic           r_out_valid;
   logic           r_out_last;

   logic           w_wr_fire;
   logic           w_wr_wrap;
   logic           w_rd_load;
   logic           w_rd_wrap;
   logic [N-1:0]   w_wr_addr;
   logic [2*W-1:0] w_rd_dat;
   logic [1:0]     w_flag_set;
   logic [1:0]     w_flag_clr;

   // Reset release synchronizer. State flops clear asynchronously but cannot move until
   // in_ready rises here, so their own unsynchronized release is harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign in_ready   = r_rst_sync[1] & ~r_full[r_wr_bank];
   assign w_wr_fire  = in_valid & in_ready;
   assign w_wr_wrap  = w_wr_fire & (r_wr_cnt == LAST);
   assign w_rd_load  = r_full[r_rd_bank] & (~r_out_valid | out_ready);
   assign w_rd_wrap  = w_rd_load & (r_rd_cnt == LAST);
   assign w_wr_addr  = N'(bitrev(32'(r_wr_cnt), N));
   assign w_flag_set = w_wr_wrap ? (2'b01 << r_wr_bank) : 2'b00;
   assign w_flag_clr = w_rd_wrap ? (2'b01 << r_rd_bank) : 2'b00;

   fft_pingpong_ram #(.N(N), .W(W)) u_ram (
      .clk       (clk),
      .i_wr_en   (w_wr_fire),
      .i_wr_bank (r_wr_bank),
      .i_wr_addr (w_wr_addr),
      .i_wr_dat  ({in_real, in_img}),
      .i_rd_bank (r_rd_bank),
      .i_rd_addr (r_rd_cnt),
      .o_rd_dat  (w_rd_dat)
   );

   // Write side: count samples and swap banks when a frame completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_cnt  <= '0;
         r_wr_bank <= 1'b0;
      end else if (w_wr_fire) begin
         r_wr_cnt <= r_wr_cnt + 1'b1;
         if (w_wr_wrap) r_wr_bank <= ~r_wr_bank;
      end
   end

   // Read side: walk the full bank in natural order and swap after its last sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_cnt  <= '0;
         r_rd_bank <= 1'b0;
      end else if (w_rd_load) begin
         r_rd_cnt <= r_rd_cnt + 1'b1;
         if (w_rd_wrap) r_rd_bank <= ~r_rd_bank;
      end
   end

   // Bank flags: set by a completed write frame, cleared by the last read; banks never coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_full <= 2'b00;
      else        r_full <= (r_full | w_flag_set) & ~w_flag_clr;
   end

   // Output register: load when empty or being consumed, otherwise hold for a stalled consumer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_dat   <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else if (w_rd_load) begin
         r_out_dat   <= w_rd_dat;
         r_out_valid <= 1'b1;
         r_out_last  <= (r_rd_cnt == LAST);
      end else if (r_out_valid & out_ready) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign out_real  = $signed(r_out_dat[2*W-1:W]);
   assign out_img   = $signed(r_out_dat[W-1:0]);

endmodule
